seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment driver for the player-client board. It extends a small wrapping input counter (for example a 5-bit position or beat index) with an internal wrap-extension counter, converts the combined value to BCD with a sequential double-dabble engine, and scans DIGITS common-anode digits. Hex mode, leading-zero blanking, per-digit decimal points and an overflow indication are included.

## Interface
- IN_W, 5: width of `inp`.
- EXT_W, 8: width of the wrap-extension counter. VAL_W = IN_W + EXT_W.
- DIGITS, 4: number of scanned digits (1..8).
- SCAN_DIV, 65536: clk cycles per digit slot (≥2).
- WRAP_HI, 29: a previous input greater than this counts toward a wrap.
- WRAP_LO, 5: a current input less than this counts toward a wrap.
- clk, input, 1: clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- inp, input, IN_W: low part of the displayed value. Sampled every cycle.
- clr_ext, input, 1: synchronous clear of the extension counter.
- hex_mode, input, 1: 1 selects hex display, 0 selects decimal.
- blank_lz, input, 1: 1 blanks leading zeros. Digit 0 is never blanked.
- dp_mask, input, DIGITS: 1 lights the decimal point of the corresponding digit.
- an, output, DIGITS: anode selects, active-low, at most one bit low.
- seven, output, 8: segments {a,b,c,d,e,f,g,dp}, active-low, a = bit 7.
- value_o, output, VAL_W: registered {ext, inp_q}.
- busy, output, 1: BCD conversion in progress.

## Operation
- Capture and extension:
  - Each edge: `inp_q <= inp`.
  - `wrap = (inp_q > WRAP_HI) && (inp < WRAP_LO)`. On wrap, `ext <= ext + 1` (mod 2^EXT_W).
  - `clr_ext` overrides wrap in the same cycle: `ext <= 0`.
  - `value_o = {ext, inp_q}`.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if `value_o != src`, load `src <= value_o` and the shift register, clear BCD, set `ovf = (value_o >= 10^DIGITS)`, then go to SHIFT.
  - SHIFT: VAL_W cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left one bit. Then go to DONE.
  - DONE: latch the BCD digits and `ovf` into the display registers, then go to IDLE.
  - `busy = (state != IDLE)`.
  - Value changes during SHIFT/DONE are not aborted. IDLE detects them afterward and reconverts.
- Digit source:
  - hex_mode = 1: digit i = nibble i of `value_o`, taken live. Nibbles beyond VAL_W are 0. No overflow in hex mode.
  - hex_mode = 0: digit i = latched BCD nibble i.
  - If `ovf` is latched, every digit shows a dash: 8'b11111101, with dp per `dp_mask`.
- Glyphs, bits [7:1]; dp bit = ~dp_mask[i]:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Blanking: with blank_lz = 1, digit i > 0 shows 1111111 on bits [7:1] if it and all higher digits are 0. The dp still follows `dp_mask`.
- Scan: `scnt` counts SCAN_DIV-1 down to 0. At 0 it reloads, advances `idx` 0→1→…→DIGITS-1→0, and registers `an` and `seven` for the new idx in the same cycle.

## Timing
- Reset values, all outputs:
  - `an` = all ones, `seven` = 8'hFF, `value_o` = 0, `busy` = 0.
  - `ext`, `inp_q`, `src` = 0. State IDLE, idx = DIGITS-1, scnt = SCAN_DIV-1. Display BCD = 0, ovf = 0.
- The first digit-0 select occurs SCAN_DIV edges after reset release.
- Conversion latency:
  - inp change sampled at edge E0 (`value_o` updates).
  - IDLE loads at E1; busy rises after E1.
  - Shifts on E2..E(VAL_W+1).
  - Display regs update at E(VAL_W+2).
  - `seven` reflects the new value at the next scan slot for each digit.
- Wrap at 2^EXT_W-1 rolls `ext` to 0 with no flag.
- Reset asserted mid-conversion: all state returns to reset values on that edge, and the partial result is discarded.
- Mode or blank changes take effect at the next scan slot. No reconversion is required.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles → `an` = 4'b1111, `seven` = 8'hFF, `busy` = 0, `value_o` = 0.
- Wrap counting: inp ramps 0..31 three times, then inp = 4 → `value_o` = 100. After 15 cycles, `busy` = 0. With blank_lz = 1 and SCAN_DIV = 4, the digits scan `1 0 0` plus a blank, with `an` order 1110, 1101, 1011, 0111, every 4 cycles.
- clr_ext and wrap together: `inp_q` = 31, inp = 0, clr_ext = 1 → ext = 0, not incremented. `value_o` = 0.
- Hex mode: value 0x1AB with hex_mode = 1 → digits B, A, 1, 0 (blanked if blank_lz = 1). The glyph for A is 8'b00010001.
- Overflow: DIGITS = 2, value 100, decimal → both digits show 8'b11111101. Switching to hex → digits show 4 and 6.
- Reset mid-conversion: pulse rst_n low at cycle 5 of SHIFT → `busy` = 0 after that edge, display returns to 0, and no stale digits are latched.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: extends a small wrapping input with a
// wrap-count extension, converts the result to BCD with a sequential
// double-dabble engine and scans DIGITS common-anode digits.
//
// state | meaning
// IDLE  | waiting for value_o to differ from the last converted source
// SHIFT | double-dabble add-3/shift, one bit per cycle, VAL_W cycles
// DONE  | copy BCD result and overflow flag into the display registers
module seg_scan_display #(
  parameter int IN_W     = 5,
  parameter int EXT_W    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 65536,
  parameter int WRAP_HI  = 29,
  parameter int WRAP_LO  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        inp,
  input  logic                   clr_ext,
  input  logic                   hex_mode,
  input  logic                   blank_lz,
  input  logic [DIGITS-1:0]      dp_mask,
  output logic [DIGITS-1:0]      an,
  output logic [7:0]             seven,
  output logic [IN_W+EXT_W-1:0]  value_o,
  output logic                   busy
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  localparam int VAL_W  = IN_W + EXT_W;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(VAL_W + 1);
  localparam int SCNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IN_W-1:0]   WRAP_HI_V = IN_W'(WRAP_HI);
  localparam logic [IN_W-1:0]   WRAP_LO_V = IN_W'(WRAP_LO);
  localparam logic [CNT_W-1:0]  CNT_LD    = CNT_W'(VAL_W - 1);
  localparam logic [SCNT_W-1:0] SCNT_RLD  = SCNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [63:0]       OVF_LIM   = pow10(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [IN_W-1:0]   inp_q;
  logic [EXT_W-1:0]  ext_q;
  logic [VAL_W-1:0]  value_q;
  logic              wrap;

  state_t            state_q, state_d;
  logic [VAL_W-1:0]  src_q, src_d, sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
  logic              disp_ovf_q, disp_ovf_d;

  logic [SCNT_W-1:0] scnt_q;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seven_q, seven_d;
  logic [BCD_W-1:0]  hex_src;
  logic [3:0]        dig [DIGITS];
  logic [DIGITS-1:0] blank;
  logic              zero_above;
  logic [6:0]        seg;

  assign wrap    = (inp_q > WRAP_HI_V) && (inp < WRAP_LO_V);
  assign value_q = {ext_q, inp_q};
  assign value_o = value_q;
  assign busy    = (state_q != S_IDLE);
  assign hex_src = BCD_W'(value_q);
  assign an      = an_q;
  assign seven   = seven_q;

  // Input capture and wrap-extension counter; clear wins over a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inp_q <= '0;
      ext_q <= '0;
    end else begin
      inp_q <= inp;
      if (clr_ext)   ext_q <= '0;
      else if (wrap) ext_q <= ext_q + EXT_W'(1);
    end
  end

  // Converter state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // Converter next state: load on change, add-3/shift, then publish.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (value_q != src_q) begin
          src_d   = value_q;
          sh_d    = value_q;
          bcd_d   = '0;
          cnt_d   = CNT_LD;
          ovf_d   = (64'(value_q) >= OVF_LIM);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Upper BCD bits beyond DIGITS are dropped; that case shows as overflow.
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Glyph for the digit that becomes active at the next scan slot.
  always_comb begin
    idx_n      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig[i]     = hex_mode ? hex_src[4*i +: 4] : disp_bcd_q[4*i +: 4];
      zero_above = zero_above && (dig[i] == 4'd0);
      blank[i]   = blank_lz && zero_above && (i != 0);
    end
    if (disp_ovf_q && !hex_mode) seg = 7'b1111110;
    else if (blank[idx_n])       seg = 7'b1111111;
    else                         seg = glyph(dig[idx_n]);
    seven_d = {seg, ~dp_mask[idx_n]};
    an_d    = ~(DIGITS'(1) << idx_n);
  end

  // Scan timer: reload and register the next digit's anode and segments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt_q  <= SCNT_RLD;
      idx_q   <= IDX_LAST;
      an_q    <= '1;
      seven_q <= 8'hFF;
    end else if (scnt_q == '0) begin
      scnt_q  <= SCNT_RLD;
      idx_q   <= idx_n;
      an_q    <= an_d;
      seven_q <= seven_d;
    end else begin
      scnt_q  <= scnt_q - SCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a 4-digit instance carries the table-driven
// display checks; a 2-digit instance covers the overflow dash case.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  inp;
  logic        clr_ext, hex_mode, blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an1;
  logic [7:0]  seven1;
  logic [12:0] value1;
  logic        busy1;
  logic [1:0]  an2;
  logic [7:0]  seven2;
  logic [12:0] value2;
  logic        busy2;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seven;
  } exp_t;

  typedef struct {
    int              val;
    bit              hex;
    bit              blz;
    logic [3:0]      dp;
    logic [3:0][7:0] exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic [3:0] prev_an = 4'b1111;
  vec_t vecs[12];

  always #5 clk = ~clk;

  seg_scan_display #(.IN_W(5), .EXT_W(8), .DIGITS(4), .SCAN_DIV(4),
                     .WRAP_HI(29), .WRAP_LO(5)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .clr_ext(clr_ext),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .an(an1), .seven(seven1), .value_o(value1), .busy(busy1));

  seg_scan_display #(.IN_W(5), .EXT_W(8), .DIGITS(2), .SCAN_DIV(4),
                     .WRAP_HI(29), .WRAP_LO(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .clr_ext(clr_ext),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .dp_mask(dp_mask[1:0]),
    .an(an2), .seven(seven2), .value_o(value2), .busy(busy2));

  // Scoreboard consumer: each new scan slot pops one expected {an, seven}.
  always @(negedge clk) begin
    if (an1 !== prev_an && sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      tests++;
      if ({an1, seven1} !== {sb_e.an, sb_e.seven}) begin
        failed++;
        $display("FAIL scan: got an=%b seven=%h, expected an=%b seven=%h",
                 an1, seven1, sb_e.an, sb_e.seven);
      end
    end
    prev_an = an1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic goto_value(input int v);
    @(negedge clk);
    clr_ext = 1'b1;
    inp     = 5'd0;
    @(negedge clk);
    clr_ext = 1'b0;
    for (int w = 0; w < (v >> 5); w++) begin
      inp = 5'd31;
      @(negedge clk);
      inp = 5'd0;
      @(negedge clk);
    end
    inp = 5'(v & 31);
    @(negedge clk);
    check("value", int'(value1), v);
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy1) quiet++;
      else        quiet = 0;
    end
    check("settle_idle", quiet, 3);
  endtask

  task automatic scan_check(input logic [3:0][7:0] exp);
    int n = 0;
    while (an1 !== 4'b0111 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (an1 !== 4'b0111) begin
      tests++;
      failed++;
      $display("FAIL align: timeout, an=%b", an1);
    end
    @(posedge clk);
    #1;
    sb_q.push_back('{4'b1110, exp[0]});
    sb_q.push_back('{4'b1101, exp[1]});
    sb_q.push_back('{4'b1011, exp[2]});
    sb_q.push_back('{4'b0111, exp[3]});
    repeat (20) @(negedge clk);
    check("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic wait_an2(input logic [1:0] target, input string name);
    logic [1:0] prev;
    bit found;
    found = 1'b0;
    prev  = an2;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (an2 !== prev && an2 === target) found = 1'b1;
      prev = an2;
    end
    if (!found) begin
      tests++;
      failed++;
      $display("FAIL %s: timeout waiting for an=%b", name, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{100,  1'b0, 1'b1, 4'b0000, {8'hFF, 8'h9F, 8'h03, 8'h03}};
    vecs[1]  = '{100,  1'b0, 1'b0, 4'b0000, {8'h03, 8'h9F, 8'h03, 8'h03}};
    vecs[2]  = '{427,  1'b1, 1'b1, 4'b0000, {8'hFF, 8'h9F, 8'h11, 8'hC1}};
    vecs[3]  = '{427,  1'b1, 1'b0, 4'b0010, {8'h03, 8'h9F, 8'h10, 8'hC1}};
    vecs[4]  = '{427,  1'b0, 1'b1, 4'b0000, {8'hFF, 8'h99, 8'h25, 8'h1F}};
    vecs[5]  = '{8191, 1'b0, 1'b0, 4'b1000, {8'h00, 8'h9F, 8'h09, 8'h9F}};
    vecs[6]  = '{0,    1'b0, 1'b1, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[7]  = '{0,    1'b0, 1'b1, 4'b1111, {8'hFE, 8'hFE, 8'hFE, 8'h02}};
    vecs[8]  = '{5039, 1'b0, 1'b0, 4'b0000, {8'h49, 8'h03, 8'h0D, 8'h09}};
    vecs[9]  = '{4077, 1'b1, 1'b1, 4'b0000, {8'hFF, 8'h71, 8'h61, 8'h85}};
    vecs[10] = '{6,    1'b0, 1'b1, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h41}};
    vecs[11] = '{2468, 1'b0, 1'b1, 4'b0000, {8'h25, 8'h99, 8'h41, 8'h01}};

    rst_n = 1'b0; inp = 5'd0; clr_ext = 1'b0;
    hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;

    // Reset values, then first digit-0 select SCAN_DIV edges after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", int'(an1), 4'hF);
    check("rst_seven", int'(seven1), 8'hFF);
    check("rst_busy", int'(busy1), 0);
    check("rst_value", int'(value1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) check("an_before_first", int'(an1), 4'hF);
      if (k == 4) begin
        check("first_select", int'(an1), 4'b1110);
        check("first_seven", int'(seven1), 8'h03);
      end
    end

    // Wrap counting: three ramps 0..31 then 4 gives three wraps -> 100.
    @(negedge clk);
    clr_ext = 1'b1;
    inp = 5'd0;
    @(negedge clk);
    clr_ext = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        inp = 5'(i);
        @(negedge clk);
      end
    end
    inp = 5'd4;
    @(negedge clk);
    check("wrap_value", int'(value1), 100);
    check("wrap_value2", int'(value2), 100);
    blank_lz = 1'b1;
    settle();
    scan_check({8'hFF, 8'h9F, 8'h03, 8'h03});

    // Overflow on the 2-digit instance: dashes in decimal, 6/4 in hex.
    wait_an2(2'b10, "ovf_d0");
    check("ovf_dash_d0", int'(seven2), 8'hFD);
    wait_an2(2'b01, "ovf_d1");
    check("ovf_dash_d1", int'(seven2), 8'hFD);
    hex_mode = 1'b1;
    wait_an2(2'b01, "hex_sync");
    wait_an2(2'b10, "hex_d0");
    check("ovf_hex_d0", int'(seven2), 8'h99);
    wait_an2(2'b01, "hex_d1");
    check("ovf_hex_d1", int'(seven2), 8'h41);
    hex_mode = 1'b0;

    // clr_ext overrides a simultaneous wrap; a plain wrap increments.
    inp = 5'd31;
    @(negedge clk);
    @(negedge clk);
    inp = 5'd0;
    clr_ext = 1'b1;
    @(negedge clk);
    clr_ext = 1'b0;
    check("clr_over_wrap", int'(value1), 0);
    inp = 5'd31;
    @(negedge clk);
    @(negedge clk);
    inp = 5'd0;
    @(negedge clk);
    check("wrap_inc", int'(value1), 32);

    // Table of display vectors.
    for (int i = 0; i < 12; i++) begin
      hex_mode = vecs[i].hex;
      blank_lz = vecs[i].blz;
      dp_mask  = vecs[i].dp;
      goto_value(vecs[i].val);
      settle();
      scan_check(vecs[i].exp);
    end

    // Extension counter rolls over silently from all ones.
    hex_mode = 1'b0; blank_lz = 1'b1; dp_mask = 4'b0000;
    goto_value(8191);
    inp = 5'd0;
    @(negedge clk);
    check("ext_roll", int'(value1), 0);

    // Reset in the middle of a conversion discards the partial result.
    goto_value(427);
    settle();
    inp = 5'd20;
    begin
      int n = 0;
      while (!busy1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("conv_start", int'(busy1), 1);
    end
    repeat (4) @(negedge clk);
    check("still_busy", int'(busy1), 1);
    rst_n = 1'b0;
    inp = 5'd0;
    @(posedge clk);
    #1;
    check("midrst_busy", int'(busy1), 0);
    check("midrst_value", int'(value1), 0);
    check("midrst_an", int'(an1), 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    scan_check({8'hFF, 8'hFF, 8'hFF, 8'h03});
    check("no_stale_conv", int'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
